// File: rtl/core_lsu_mem_ctrl_pkg.sv
// Shared definitions for the LSU data-memory controller: FSM encodings and default timeout.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// A project-wide defines header may predefine any of the macros below before this
// package is compiled; otherwise the local fallback values apply.

`ifndef CORE_LSU_TIMEOUT_CYCLES
`define CORE_LSU_TIMEOUT_CYCLES 16
`endif
`ifndef CORE_LSU_ST_IDLE
`define CORE_LSU_ST_IDLE 3'd0
`endif
`ifndef CORE_LSU_ST_REQ
`define CORE_LSU_ST_REQ 3'd1
`endif
`ifndef CORE_LSU_ST_WAIT
`define CORE_LSU_ST_WAIT 3'd2
`endif
`ifndef CORE_LSU_ST_DONE
`define CORE_LSU_ST_DONE 3'd3
`endif
`ifndef CORE_LSU_ST_ERR
`define CORE_LSU_ST_ERR 3'd4
`endif

package core_lsu_mem_ctrl_pkg;

    localparam int DEF_TIMEOUT_CYCLES = `CORE_LSU_TIMEOUT_CYCLES;

    typedef enum logic [2:0] {
        ST_IDLE = `CORE_LSU_ST_IDLE,
        ST_REQ  = `CORE_LSU_ST_REQ,
        ST_WAIT = `CORE_LSU_ST_WAIT,
        ST_DONE = `CORE_LSU_ST_DONE,
        ST_ERR  = `CORE_LSU_ST_ERR
    } lsu_state_t;

endpackage

// File: rtl/core_lsu_timeout_cnt.sv
// Per-phase wait counter; expired is high when the count reaches TIMEOUT_CYCLES-1.
// Latency: expired reflects the registered count (no combinational path from inputs).
// Backpressure: none; the owner decides when to clear and enable.
//
// Ports: clk, rst (sync, active-high), clear (restart at 0, wins over enable),
//        enable (count one cycle), expired (count == TIMEOUT_CYCLES-1).

module core_lsu_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/core_lsu_mem_ctrl.sv
// LSU data-memory controller: one load/store at a time over a req/gnt + rvalid bus.
// Latency: 3 cycles request-to-done minimum (gnt and rvalid both in their first cycle).
// Backpressure: stall_o freezes the pipeline from request until DONE/ERR; each phase times out.
//
// Ports: clk_i/rst_i (sync, active-high); ls_* request from the execution unit;
//        stall_o/done_o/err_o/rdata_o back to the pipeline; data_* to/from the memory.

module core_lsu_mem_ctrl
    import core_lsu_mem_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ls_req_i,
    input  logic                      ls_we_i,
    input  logic [MEM_ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0]     ls_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   ls_be_i,
    output logic                      stall_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    output logic                      data_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   data_be_o,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i
);

    typedef struct packed {
        logic                      we;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [DATA_WIDTH/8-1:0]   be;
    } ls_req_t;

    lsu_state_t state;
    ls_req_t    req_q;
    logic       expired;
    logic       gnt_hs;
    logic       rv_hs;
    logic       cnt_clr;
    logic       cnt_en;

    // rvalid only counts in WAIT and gnt only in REQ; both are ignored elsewhere.
    assign gnt_hs  = (state == ST_REQ)  && data_gnt_i;
    assign rv_hs   = (state == ST_WAIT) && data_rvalid_i;

    // Restart the count on the cycle before each phase begins, so the first
    // cycle of REQ and of WAIT both see a count of 0.
    assign cnt_clr = ((state == ST_IDLE) && ls_req_i) || gnt_hs;
    assign cnt_en  = (state == ST_REQ) || (state == ST_WAIT);

    core_lsu_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk_i),
        .rst    (rst_i),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .expired(expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            rdata_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ls_req_i) begin
                        req_q <= '{we: ls_we_i, addr: ls_addr_i, wdata: ls_wdata_i, be: ls_be_i};
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A grant in the last allowed cycle still wins over the timeout.
                    if (data_gnt_i) begin
                        state <= ST_WAIT;
                    end else if (expired) begin
                        state <= ST_ERR;
                    end
                end
                ST_WAIT: begin
                    if (rv_hs) begin
                        if (!req_q.we) begin
                            rdata_o <= data_rdata_i;
                        end
                        state <= ST_DONE;
                    end else if (expired) begin
                        state <= ST_ERR;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus fields are forced to zero outside REQ so the memory never sees stale values.
    assign data_req_o   = (state == ST_REQ);
    assign data_we_o    = data_req_o & req_q.we;
    assign data_addr_o  = data_req_o ? req_q.addr  : '0;
    assign data_wdata_o = data_req_o ? req_q.wdata : '0;
    assign data_be_o    = data_req_o ? req_q.be    : '0;

    assign done_o  = (state == ST_DONE);
    assign err_o   = (state == ST_ERR);
    assign stall_o = (state == ST_REQ) || (state == ST_WAIT) || ((state == ST_IDLE) && ls_req_i);

endmodule

// File: tb/tb_core_lsu_mem_ctrl.sv
// Self-checking bench for core_lsu_mem_ctrl: directed scenarios plus randomized accesses.
// Each access is predicted as a timeline (request cycle, REQ span, WAIT span, end cycle)
// derived from the grant/rvalid delays the bench chooses, and every cycle is compared.

module tb_core_lsu_mem_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int T  = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ls_req_i;
    logic          ls_we_i;
    logic [AW-1:0] ls_addr_i;
    logic [DW-1:0] ls_wdata_i;
    logic [3:0]    ls_be_i;
    logic          stall_o;
    logic          done_o;
    logic          err_o;
    logic [DW-1:0] rdata_o;
    logic          data_req_o;
    logic          data_gnt_i;
    logic          data_we_o;
    logic [AW-1:0] data_addr_o;
    logic [DW-1:0] data_wdata_o;
    logic [3:0]    data_be_o;
    logic          data_rvalid_i;
    logic [DW-1:0] data_rdata_i;

    int            vectors;
    int            miscompares;
    logic [DW-1:0] exp_rdata;

    core_lsu_mem_ctrl #(
        .MEM_ADDR_WIDTH(AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ls_req_i     (ls_req_i),
        .ls_we_i      (ls_we_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .ls_be_i      (ls_be_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_we_o    (data_we_o),
        .data_addr_o  (data_addr_o),
        .data_wdata_o (data_wdata_o),
        .data_be_o    (data_be_o),
        .data_rvalid_i(data_rvalid_i),
        .data_rdata_i (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against one cycle's expectation.
    task automatic chk_cycle(input string ctx, input bit stall, input bit req, input bit we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input logic [3:0] be, input bit done, input bit err);
        chk({ctx, ".stall"}, DW'(stall_o),      DW'(stall));
        chk({ctx, ".req"},   DW'(data_req_o),   DW'(req));
        chk({ctx, ".we"},    DW'(data_we_o),    DW'(req && we));
        chk({ctx, ".addr"},  DW'(data_addr_o),  req ? DW'(addr) : '0);
        chk({ctx, ".wdata"}, data_wdata_o,      req ? wd : '0);
        chk({ctx, ".be"},    DW'(data_be_o),    req ? DW'(be) : '0);
        chk({ctx, ".done"},  DW'(done_o),       DW'(done));
        chk({ctx, ".err"},   DW'(err_o),        DW'(err));
        chk({ctx, ".rdata"}, rdata_o,           exp_rdata);
    endtask

    // n cycles with no request; memory-side inputs carry noise that must be ignored.
    task automatic idle(input int n, input string ctx);
        for (int c = 0; c < n; c++) begin
            rst_i         = 1'b0;
            ls_req_i      = 1'b0;
            ls_we_i       = 1'($urandom);
            ls_addr_i     = AW'($urandom);
            ls_wdata_i    = $urandom;
            ls_be_i       = 4'($urandom);
            data_gnt_i    = 1'($urandom);
            data_rvalid_i = 1'($urandom);
            data_rdata_i  = $urandom;
            @(negedge clk_i);
            chk_cycle(ctx, 0, 0, 0, '0, '0, '0, 0, 0);
            @(posedge clk_i);
            #1;
        end
    endtask

    // One access. gd = REQ cycles without grant before the grant cycle (>= T: never),
    // rd = WAIT cycles before rvalid (>= T: never). rst_c >= 0 pulses reset in that
    // cycle of the access. hold keeps ls_req_i high after the request cycle.
    task automatic run_access(input string ctx, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, input logic [3:0] be,
                              input int gd, input int rd, input logic [DW-1:0] rv_data,
                              input int rst_c, input bit hold);
        bit g_ok, r_ok, ok, in_req, in_wait;
        int n_req, n_wait, end_c, last_c, rv_c;
        g_ok   = (gd < T);
        r_ok   = (rd < T);
        ok     = g_ok && r_ok;
        n_req  = g_ok ? gd + 1 : T;
        n_wait = r_ok ? rd + 1 : T;
        end_c  = g_ok ? n_req + n_wait + 1 : n_req + 1;
        last_c = (rst_c >= 0) ? rst_c : end_c;
        rv_c   = n_req + 1 + rd;
        for (int c = 0; c <= last_c; c++) begin
            in_req  = (c >= 1) && (c <= n_req);
            in_wait = g_ok && (c > n_req) && (c <= n_req + n_wait);
            rst_i   = (c == rst_c);
            if (c == 0) begin
                ls_req_i   = 1'b1;
                ls_we_i    = we;
                ls_addr_i  = addr;
                ls_wdata_i = wd;
                ls_be_i    = be;
            end else begin
                // Pipeline-side inputs change freely; the latched request must not.
                ls_req_i   = hold ? 1'b1 : 1'($urandom);
                ls_we_i    = 1'($urandom);
                ls_addr_i  = AW'($urandom);
                ls_wdata_i = $urandom;
                ls_be_i    = 4'($urandom);
            end
            data_gnt_i    = in_req && (c == 1 + gd);
            data_rvalid_i = in_wait ? (c == rv_c) : (in_req ? 1'($urandom) : 1'b0);
            data_rdata_i  = (in_wait && c == rv_c) ? rv_data : $urandom;
            @(negedge clk_i);
            if (c == end_c && ok && !we) exp_rdata = rv_data;
            chk_cycle(ctx, c < end_c, in_req, we, addr, wd, be,
                      ok && c == end_c, !ok && c == end_c);
            @(posedge clk_i);
            #1;
        end
        if (rst_c >= 0) begin
            exp_rdata = '0;
            idle(1, {ctx, ".post_rst"});
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        exp_rdata     = '0;
        rst_i         = 1'b1;
        ls_req_i      = 1'b0;
        ls_we_i       = 1'b0;
        ls_addr_i     = '0;
        ls_wdata_i    = '0;
        ls_be_i       = '0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk_cycle("reset", 0, 0, 0, '0, '0, '0, 0, 0);
        // Stall follows the request even while reset is held.
        ls_req_i = 1'b1;
        #1;
        chk("reset.stall_req", DW'(stall_o), DW'(1));
        @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        ls_req_i = 1'b0;
        idle(2, "idle0");

        // Zero-wait load.
        run_access("load0", 1'b0, 10'h010, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF, -1, 0);
        // Store, grant after 4 wait cycles; rdata must stay.
        run_access("store_ws", 1'b1, 10'h3FC, 32'h12345678, 4'hF, 4, 1, 32'h55AA55AA, -1, 0);
        // Grant never arrives.
        run_access("gnt_to", 1'b0, 10'h0A0, 32'h0, 4'h3, T + 5, 0, 32'h11111111, -1, 0);
        idle(1, "after_gnt_to");
        // Grant in the last allowed REQ cycle.
        run_access("gnt_last", 1'b0, 10'h104, 32'h0, 4'hF, T - 1, 2, 32'hCAFEF00D, -1, 0);
        // rvalid never arrives; rdata keeps the previous load.
        run_access("rv_to", 1'b0, 10'h108, 32'h0, 4'hF, 1, T + 2, 32'h22222222, -1, 0);
        // rvalid in the last allowed WAIT cycle.
        run_access("rv_last", 1'b0, 10'h10C, 32'h0, 4'hF, 0, T - 1, 32'h0BADCAFE, -1, 0);
        // Reset pulse in the fourth WAIT cycle, then a clean load.
        run_access("rst_wait", 1'b0, 10'h200, 32'h0, 4'hF, 0, 20, 32'h33333333, 5, 0);
        run_access("after_rst", 1'b0, 10'h204, 32'h0, 4'hF, 0, 0, 32'h000000A5, -1, 0);
        // Back-to-back with ls_req_i held high through DONE.
        run_access("b2b0", 1'b1, 10'h300, 32'hA5A5A5A5, 4'h5, 1, 0, 32'h0, -1, 1);
        run_access("b2b1", 1'b0, 10'h304, 32'h0, 4'hF, 0, 1, 32'h76543210, -1, 0);
        idle(1, "after_b2b");

        for (int i = 0; i < 60; i++) begin
            int gd;
            int rd;
            bit hold;
            gd   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(T - 2, T + 1))
                                               : int'($urandom_range(0, 5));
            rd   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(T - 2, T + 1))
                                               : int'($urandom_range(0, 5));
            hold = ($urandom_range(0, 3) == 0);
            run_access("rand", 1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                       gd, rd, $urandom, -1, hold);
            if (!hold) idle(int'($urandom_range(0, 2)), "rand_gap");
        end
        idle(1, "final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_lsu_mem_ctrl.md
CORE_LSU_MEM_CTRL -- requirements
Module: core_lsu_mem_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- MEM_ADDR_WIDTH, 10, data-memory byte address width.
- DATA_WIDTH, 32, data word width.
- TIMEOUT_CYCLES, 16, maximum wait cycles per handshake phase; legal range 2..255.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, reset; synchronous, active-high.
- ls_req_i, in, 1, execution unit requests a load or store.
- ls_we_i, in, 1, 1 = store, 0 = load.
- ls_addr_i, in, MEM_ADDR_WIDTH, byte address from the LIS path.
- ls_wdata_i, in, DATA_WIDTH, store data, already lane-aligned.
- ls_be_i, in, DATA_WIDTH/8, byte enables.
- stall_o, out, 1, freeze the pipeline.
- done_o, out, 1, one-cycle pulse when the access completes.
- err_o, out, 1, one-cycle pulse when the access times out.
- rdata_o, out, DATA_WIDTH, captured load data.
- data_req_o, out, 1, memory request.
- data_gnt_i, in, 1, memory grant.
- data_we_o, out, 1, memory write enable.
- data_addr_o, out, MEM_ADDR_WIDTH, memory address.
- data_wdata_o, out, DATA_WIDTH, memory write data.
- data_be_o, out, DATA_WIDTH/8, memory byte enables.
- data_rvalid_i, in, 1, memory response valid.
- data_rdata_i, in, DATA_WIDTH, memory response data.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, REQ, WAIT, DONE, ERR.
REQ-004 In IDLE with ls_req_i=1:
- ls_we_i, ls_addr_i, ls_wdata_i and ls_be_i SHALL be registered.
- The next state SHALL be REQ.
- stall_o SHALL be 1 combinationally in that same cycle.
REQ-005 In REQ:
- data_req_o SHALL be 1.
- data_we/addr/wdata/be SHALL come from the registered fields and stay stable until data_gnt_i=1.
- On data_gnt_i=1 the next state SHALL be WAIT.
REQ-006 In WAIT:
- data_req_o SHALL be 0.
- data_rvalid_i SHALL be ignored in REQ.
- On data_rvalid_i=1 the next state SHALL be DONE.
- For a load, data_rdata_i SHALL be captured into rdata_o.
- For a store, rdata_o SHALL be unchanged.
REQ-007 In DONE:
- done_o=1 and stall_o=0 for exactly one cycle.
- The next state SHALL be IDLE.
- ls_req_i SHALL be ignored in DONE.
- Minimum request-to-done latency SHALL be 3 cycles (gnt in the first REQ cycle, rvalid in the first WAIT cycle).
REQ-008 stall_o SHALL be 1 in REQ and WAIT, and in IDLE when ls_req_i=1. Otherwise it SHALL be 0.
REQ-009 Timeout counter:
- A cycle counter of width clog2(TIMEOUT_CYCLES) SHALL clear on entry to REQ and on entry to WAIT.
- It SHALL increment every cycle spent in either state.
REQ-010 If the counter equals TIMEOUT_CYCLES-1 without the awaited handshake (gnt in REQ, rvalid in WAIT), the next state SHALL be ERR and data_req_o SHALL drop the next cycle.
REQ-011 In ERR:
- err_o=1 and stall_o=0 for one cycle.
- rdata_o SHALL be unchanged.
- The next state SHALL be IDLE.
REQ-012 When the handshake arrives in the same cycle the counter reaches TIMEOUT_CYCLES-1, the handshake SHALL win (normal transition, no err_o).
REQ-013 done_o and err_o SHALL never be 1 in the same cycle.
REQ-014 rdata_o SHALL hold its value until the next load capture.
REQ-015 data_we_o, data_addr_o, data_wdata_o and data_be_o SHALL be 0 whenever data_req_o=0.

Reset
REQ-016 With rst_i=1 at a clk_i edge:
- state SHALL become IDLE.
- The counter, the registered request fields and rdata_o SHALL become 0.
REQ-017 During and after reset, all outputs SHALL be 0 until a new request, except that stall_o follows REQ-008.
REQ-018 Reset asserted mid-access (REQ or WAIT) SHALL abort the access:
- data_req_o SHALL be 0 the cycle after the reset edge.
- No done_o or err_o SHALL be generated.

Structure
REQ-019 FSM state encodings and the default TIMEOUT_CYCLES SHALL live in the shared defines header (CUSTOM_DEFINE path). Local fallback defaults SHALL otherwise be used.
REQ-020 The timeout counter SHALL be one sub-module, core_lsu_timeout_cnt (inputs clear/enable, output expired). All other logic SHALL be in core_lsu_mem_ctrl.

Verification
REQ-021 Load, zero-wait: addr=0x010, gnt in the first REQ cycle, rvalid+rdata=0xDEADBEEF in the first WAIT cycle -> done_o at cycle 3, rdata_o=0xDEADBEEF, stall_o high for cycles 0-2.
REQ-022 Store with wait states: we=1, addr=0x3FC, wdata=0x12345678, be=0xF, gnt delayed 4 cycles -> data_addr_o/data_wdata_o/data_be_o stable across all 5 REQ cycles, done_o after rvalid, rdata_o unchanged.
REQ-023 Grant timeout: TIMEOUT_CYCLES=16, gnt never asserted -> err_o pulse after 16 REQ cycles, data_req_o low the next cycle, FSM back in IDLE, no done_o.
REQ-024 Boundary: gnt arriving exactly in the 16th REQ cycle -> WAIT entered, no err_o. rvalid timeout in WAIT -> err_o, rdata_o keeps its previous value.
REQ-025 Reset mid-WAIT: rst_i pulsed for 1 cycle -> IDLE, rdata_o=0, no done_o/err_o. A following load (rdata 0x000000A5) completes normally.
REQ-026 Back-to-back: ls_req_i held high through DONE -> second access starts in the IDLE cycle after DONE, with exactly one done_o per access.
